// File: rtl/rv32_decode_stage.sv
`default_nettype none
// =============================================================================
// Module   : rv32_decode_stage
// Brief    : Registered RV32I decoder with a main + skid elastic buffer and flush.
// Revision : 1.0
// =============================================================================
module rv32_decode_stage #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int CHECK_ILL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_fmt,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic              out_rd_we,
    output logic              out_rs1_en,
    output logic              out_rs2_en,
    output logic [2:0]        out_func3,
    output logic [6:0]        out_func7,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] c_FMT_R   = 3'd0;
    localparam logic [2:0] c_FMT_I   = 3'd1;
    localparam logic [2:0] c_FMT_S   = 3'd2;
    localparam logic [2:0] c_FMT_B   = 3'd3;
    localparam logic [2:0] c_FMT_U   = 3'd4;
    localparam logic [2:0] c_FMT_J   = 3'd5;
    localparam logic [2:0] c_FMT_SYS = 3'd6;
    localparam logic [2:0] c_FMT_ILL = 3'd7;

    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [6:0]        opcode;
        logic [2:0]        fmt;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rd_we;
        logic              rs1_en;
        logic              rs2_en;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } dec_t;

    logic [6:0]        w_op;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [2:0]        w_fmt;
    logic [31:0]       w_imm32;
    logic              w_known;
    logic              w_bad_fn;
    logic              w_shift;
    logic              w_use_rd;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_no_f3;
    logic              w_oor;
    logic              w_ill;
    logic [REG_AW-1:0] w_rd_idx;
    dec_t              w_dec;

    assign w_op     = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_rd_idx = in_instr[7 +: REG_AW];

    always_comb begin
        w_fmt     = c_FMT_ILL;
        w_imm32   = 32'd0;
        w_known   = 1'b1;
        w_bad_fn  = 1'b0;
        w_shift   = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_no_f3   = 1'b0;
        case (w_op)
            c_OP_OP: begin
                w_fmt     = c_FMT_R;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_f7 != 7'd0 && w_f7 != c_F7_ALT)
                    w_bad_fn = 1'b1;
                if (w_f7 == c_F7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101)
                    w_bad_fn = 1'b1;
            end
            c_OP_IMM: begin
                w_fmt     = c_FMT_I;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                if (w_f3 == 3'b001) begin
                    w_shift  = 1'b1;
                    w_bad_fn = (w_f7 != 7'd0);
                end else if (w_f3 == 3'b101) begin
                    w_shift  = 1'b1;
                    w_bad_fn = (w_f7 != 7'd0 && w_f7 != c_F7_ALT);
                end
            end
            c_OP_LOAD, c_OP_JALR: begin
                w_fmt     = c_FMT_I;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                w_bad_fn  = (w_op == c_OP_JALR) && (w_f3 != 3'b000);
            end
            c_OP_SYSTEM: begin
                w_fmt     = c_FMT_SYS;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            c_OP_FENCE: w_fmt = c_FMT_SYS;
            c_OP_STORE: begin
                w_fmt     = c_FMT_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            c_OP_BRANCH: begin
                w_fmt     = c_FMT_B;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
                w_bad_fn  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_fmt    = c_FMT_U;
                w_use_rd = 1'b1;
                w_no_f3  = 1'b1;
                w_imm32  = {in_instr[31:12], 12'd0};
            end
            c_OP_JAL: begin
                w_fmt    = c_FMT_J;
                w_use_rd = 1'b1;
                w_no_f3  = 1'b1;
                w_imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            default: w_known = 1'b0;
        endcase
    end

    // Only index fields the format actually reads can make the word illegal.
    assign w_oor = (w_use_rd  && ((in_instr[11:7]  >> REG_AW) != 5'd0)) ||
                   (w_use_rs1 && ((in_instr[19:15] >> REG_AW) != 5'd0)) ||
                   (w_use_rs2 && ((in_instr[24:20] >> REG_AW) != 5'd0));

    assign w_ill = (CHECK_ILL != 0) &&
                   ((in_instr[1:0] != 2'b11) || !w_known || w_bad_fn || w_oor);

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = w_op;
        w_dec.func3   = w_no_f3 ? 3'd0 : w_f3;
        if (w_ill) begin
            w_dec.fmt     = c_FMT_ILL;
            w_dec.illegal = 1'b1;
        end else begin
            w_dec.fmt    = w_fmt;
            w_dec.rd     = w_use_rd  ? w_rd_idx : '0;
            w_dec.rs1    = w_use_rs1 ? in_instr[15 +: REG_AW] : '0;
            w_dec.rs2    = w_use_rs2 ? in_instr[20 +: REG_AW] : '0;
            w_dec.rd_we  = w_use_rd && (w_rd_idx != '0);
            w_dec.rs1_en = w_use_rs1;
            w_dec.rs2_en = w_use_rs2;
            w_dec.func7  = ((w_fmt == c_FMT_R) || w_shift) ? w_f7 : 7'd0;
            w_dec.imm    = XLEN'($signed(w_imm32));
        end
    end

    dec_t r_main;
    dec_t r_skid;
    logic r_main_v;
    logic r_skid_v;
    logic r_in_ready;

    dec_t w_main_nxt;
    dec_t w_skid_nxt;
    logic w_main_v_nxt;
    logic w_skid_v_nxt;
    logic w_accept;

    assign w_accept = in_valid && r_in_ready && !flush;

    always_comb begin
        w_main_nxt   = r_main;
        w_skid_nxt   = r_skid;
        w_main_v_nxt = r_main_v;
        w_skid_v_nxt = r_skid_v;
        if (flush) begin
            w_main_nxt   = '0;
            w_skid_nxt   = '0;
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (!r_main_v || out_ready) begin
            // Skid is older than anything at the input, so it refills main first.
            if (r_skid_v) begin
                w_main_nxt   = r_skid;
                w_main_v_nxt = 1'b1;
                w_skid_v_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_nxt   = w_dec;
                w_main_v_nxt = 1'b1;
            end else begin
                w_main_v_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_nxt   = w_dec;
            w_skid_v_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_main_v   <= w_main_v_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_in_ready <= !w_skid_v_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_v;
    assign out_pc      = r_main.pc;
    assign out_opcode  = r_main.opcode;
    assign out_fmt     = r_main.fmt;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd_we   = r_main.rd_we;
    assign out_rs1_en  = r_main.rs1_en;
    assign out_rs2_en  = r_main.rs2_en;
    assign out_func3   = r_main.func3;
    assign out_func7   = r_main.func7;
    assign out_imm     = r_main.imm;
    assign out_illegal = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_rv32_decode_stage
// Brief    : Directed self-checking bench for rv32_decode_stage.
// Revision : 1.0
// =============================================================================
module tb_rv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic        out_rd_we;
    logic        out_rs1_en;
    logic        out_rs2_en;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_pc  [100];
    logic [31:0] exp_imm [100];
    logic [31:0] wrd     [100];
    logic [31:0] hold_imm;

    always #5 clk = ~clk;

    rv32_decode_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_fmt    (out_fmt),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd_we  (out_rd_we),
        .out_rs1_en (out_rs1_en),
        .out_rs2_en (out_rs2_en),
        .out_func3  (out_func3),
        .out_func7  (out_func7),
        .out_imm    (out_imm),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [2:0] fmt, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic rd_we,
                           input logic rs1_en, input logic rs2_en, input logic [31:0] imm,
                           input logic ill);
        chk({tag, "/valid"}, out_valid, 1'b1);
        chk({tag, "/fmt"}, out_fmt, fmt);
        chk({tag, "/rd"}, out_rd, rd);
        chk({tag, "/rs1"}, out_rs1, rs1);
        chk({tag, "/rs2"}, out_rs2, rs2);
        chk({tag, "/rd_we"}, out_rd_we, rd_we);
        chk({tag, "/ens"}, {out_rs1_en, out_rs2_en}, {rs1_en, rs2_en});
        chk({tag, "/imm"}, out_imm, imm);
        chk({tag, "/ill"}, out_illegal, ill);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_valid", out_valid, 1'b0);

        // Back-to-back directed decodes, one result per cycle.
        drive(32'hFFF10093, 32'h100); @(negedge clk);
        chk_dec("addi", 3'd1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
        chk("addi/pc", out_pc, 32'h100);
        drive(32'h00532423, 32'h104); @(negedge clk);
        chk_dec("sw", 3'd2, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1, 1'b1, 32'd8, 1'b0);
        chk("sw/func3", out_func3, 3'd2);
        chk("sw/pc", out_pc, 32'h104);
        drive(32'hFE000EE3, 32'h108); @(negedge clk);
        chk_dec("beq", 3'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0);
        drive(32'h123451B7, 32'h10C); @(negedge clk);
        chk_dec("lui", 3'd4, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h12345000, 1'b0);
        chk("lui/func3", out_func3, 3'd0);
        drive(32'hFF9FF0EF, 32'h110); @(negedge clk);
        chk_dec("jal", 3'd5, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF8, 1'b0);
        drive(32'h40315093, 32'h114); @(negedge clk);
        chk_dec("srai", 3'd1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'h00000403, 1'b0);
        chk("srai/func7", out_func7, 7'h20);
        drive(32'h00000000, 32'h118); @(negedge clk);
        chk_dec("ill_zero", 3'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        drive(32'h4000F033, 32'h11C); @(negedge clk);
        chk_dec("ill_f3", 3'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("ill_f3/pc", out_pc, 32'h11C);
        drive(32'h0000007F, 32'h120); @(negedge clk);
        chk_dec("ill_op", 3'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        in_valid = 1'b0; @(negedge clk);
        chk("idle_valid", out_valid, 1'b0);

        // Backpressure fills main then skid; third beat must wait.
        out_ready = 1'b0;
        drive(32'h00100093, 32'h0); @(negedge clk);
        chk("bp_ready1", in_ready, 1'b1);
        hold_imm = out_imm;
        drive(32'h00200093, 32'h4); @(negedge clk);
        chk("bp_ready2", in_ready, 1'b0);
        chk("bp_pc0", out_pc, 32'h0);
        drive(32'h00300093, 32'h8); @(negedge clk);
        chk("bp_stall_pc", out_pc, 32'h0);
        chk("bp_stall_imm", out_imm, 32'd1);
        chk("bp_stall_valid", out_valid, 1'b1);
        out_ready = 1'b1; @(negedge clk);
        chk("bp_pc4", out_pc, 32'h4);
        chk("bp_imm4", out_imm, 32'd2);
        @(negedge clk);
        chk("bp_pc8", out_pc, 32'h8);
        chk("bp_imm8", out_imm, 32'd3);
        in_valid = 1'b0; @(negedge clk);
        chk("bp_drained", out_valid, 1'b0);

        // Streaming: alternating addi / lui with random fields.
        for (int i = 0; i < 100; i++) begin
            logic [11:0] i12;
            logic [19:0] u20;
            logic [4:0]  ra;
            logic [4:0]  rb;
            i12 = 12'($urandom);
            u20 = 20'($urandom);
            ra  = 5'($urandom);
            rb  = 5'($urandom);
            exp_pc[i] = 32'h1000 + 32'(i) * 4;
            if (i % 2 == 0) begin
                wrd[i]     = {i12, rb, 3'b000, ra, 7'b0010011};
                exp_imm[i] = {{20{i12[11]}}, i12};
            end else begin
                wrd[i]     = {u20, ra, 7'b0110111};
                exp_imm[i] = {u20, 12'h000};
            end
        end
        drive(wrd[0], exp_pc[0]);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("stream_beat", {out_valid, out_pc, out_imm}, {1'b1, exp_pc[i], exp_imm[i]});
            if (i < 99) drive(wrd[i + 1], exp_pc[i + 1]);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream_end", out_valid, 1'b0);

        // Flush with skid full and a beat waiting at the input.
        out_ready = 1'b0;
        drive(32'h00100093, 32'h200); @(negedge clk);
        drive(32'h00200093, 32'h204); @(negedge clk);
        chk("fl_skid_full", in_ready, 1'b0);
        drive(32'h00300093, 32'h208); flush = 1'b1; @(negedge clk);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        drive(32'h00400093, 32'h20C); @(negedge clk);
        chk("fl_discard", out_valid, 1'b0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; @(negedge clk);
        chk("fl_no_stale", out_valid, 1'b0);

        // Asynchronous reset in the middle of a stream.
        drive(32'h00500093, 32'h300); @(negedge clk);
        chk("ar_pre_valid", out_valid, 1'b1);
        drive(32'h00600093, 32'h304);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_pc", out_pc, 32'd0);
        chk("ar_imm", out_imm, 32'd0);
        chk("ar_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_held", out_valid, 1'b0);
        rst_n = 1'b1; @(negedge clk);
        chk("ar_rel_ready", in_ready, 1'b1);
        chk("ar_rel_valid", out_valid, 1'b0);
        drive(32'h123451B7, 32'h400); @(negedge clk);
        chk_dec("ar_lui", 3'd4, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h12345000, 1'b0);
        chk("ar_lui/pc", out_pc, 32'h400);
        in_valid = 1'b0; @(negedge clk);
        chk("ar_end", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
